// File: rtl/alu_sched.sv
// ALU/LSU issue scheduler: latches one decoded instruction, optionally runs a
// load/store handshake with timeout, then issues a single writeback cycle.
//
// state | meaning
// IDLE  | ready for a new instruction; sched_err may pulse here after a timeout
// MEM   | load/store request held until lsu_ack or LSU_TIMEOUT cycles elapse
// EXEC  | one-cycle ALU issue with register/flag writeback
module alu_sched #(
  parameter int unsigned LSU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [3:0]  dec_alu_f,
  input  logic [1:0]  dec_mode,
  input  logic        dec_carry,
  input  logic        dec_wf,
  input  logic [15:0] dec_imm,
  input  logic [2:0]  dec_ra,
  input  logic [2:0]  dec_rb,
  input  logic [2:0]  dec_rd,
  output logic [2:0]  rf_ra_sel,
  output logic [2:0]  rf_rb_sel,
  output logic [2:0]  rf_rd_sel,
  output logic        rf_we,
  output logic        rf_sf_we,
  output logic [3:0]  alu_f,
  output logic        carry_mask,
  output logic [15:0] sched_t16,
  output logic [15:0] sched_agu_t16,
  output logic        sched_bypass_b,
  output logic        sched_zero_index,
  output logic        lsu_rd_req,
  output logic        lsu_wr_req,
  input  logic        lsu_ack,
  input  logic [15:0] lsu_rdata,
  output logic        sched_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, EXEC = 2'd2} state_t;

  localparam logic [1:0]  MODE_REG   = 2'b00;
  localparam logic [1:0]  MODE_IMM   = 2'b01;
  localparam logic [1:0]  MODE_LOAD  = 2'b10;
  localparam logic [15:0] TIMEOUT16  = 16'(LSU_TIMEOUT);
  localparam logic [3:0]  ALU_NOWB   = 4'b1111;

  state_t      state_q, state_d;
  logic [3:0]  f_q, f_d;
  logic [1:0]  mode_q, mode_d;
  logic        carry_q, carry_d;
  logic        wf_q, wf_d;
  logic [15:0] imm_q, imm_d;
  logic [2:0]  ra_q, ra_d;
  logic [2:0]  rb_q, rb_d;
  logic [2:0]  rd_q, rd_d;
  logic [15:0] opnd_q, opnd_d;
  logic [15:0] cnt_q, cnt_d;

  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [2:0]  ra_sel_q, ra_sel_d;
  logic [2:0]  rb_sel_q, rb_sel_d;
  logic [2:0]  rd_sel_q, rd_sel_d;
  logic        we_q, we_d;
  logic        sf_we_q, sf_we_d;
  logic [3:0]  alu_f_q, alu_f_d;
  logic        cmask_q, cmask_d;
  logic [15:0] t16_q, t16_d;
  logic [15:0] agu_q, agu_d;
  logic        bypass_q, bypass_d;
  logic        zidx_q, zidx_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    wf_d    = wf_q;
    imm_d   = imm_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dec_valid) begin
          f_d     = dec_alu_f;
          mode_d  = dec_mode;
          carry_d = dec_carry;
          wf_d    = dec_wf;
          imm_d   = dec_imm;
          ra_d    = dec_ra;
          rb_d    = dec_rb;
          rd_d    = dec_rd;
          state_d = dec_mode[1] ? MEM : EXEC;
          cnt_d   = dec_mode[1] ? 16'd1 : 16'd0;
        end
      end
      MEM: begin
        // A request is always outstanding in MEM, so ack is valid here; ack beats timeout.
        if (lsu_ack) begin
          cnt_d = 16'd0;
          if (mode_q == MODE_LOAD) begin
            opnd_d  = lsu_rdata;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q >= TIMEOUT16) begin
          cnt_d   = 16'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      EXEC: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in registers aligned with it.
  always_comb begin
    ready_d  = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    ra_sel_d = 3'd0;
    rb_sel_d = 3'd0;
    rd_sel_d = 3'd0;
    we_d     = 1'b0;
    sf_we_d  = 1'b0;
    alu_f_d  = 4'd0;
    cmask_d  = 1'b0;
    t16_d    = 16'd0;
    agu_d    = 16'd0;
    bypass_d = 1'b0;
    zidx_d   = 1'b0;
    rd_req_d = 1'b0;
    wr_req_d = 1'b0;

    if (state_d != IDLE) begin
      alu_f_d = f_d;
      cmask_d = carry_d;
      agu_d   = imm_d;
    end

    case (state_d)
      MEM: begin
        ra_sel_d = rb_d;
        zidx_d   = (rb_d == 3'd0);
        if (mode_d == MODE_LOAD) begin
          rd_req_d = 1'b1;
        end else begin
          wr_req_d = 1'b1;
          rb_sel_d = rd_d;
        end
      end
      EXEC: begin
        ra_sel_d = ra_d;
        rd_sel_d = rd_d;
        we_d     = (f_d != ALU_NOWB);
        sf_we_d  = wf_d;
        case (mode_d)
          MODE_REG: begin
            bypass_d = 1'b0;
            rb_sel_d = rb_d;
          end
          MODE_IMM: begin
            bypass_d = 1'b1;
            t16_d    = imm_d;
          end
          MODE_LOAD: begin
            bypass_d = 1'b1;
            t16_d    = opnd_d;
          end
          default: begin
            bypass_d = 1'b0;
          end
        endcase
      end
      default: begin
        ra_sel_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f_q      <= 4'd0;
      mode_q   <= 2'd0;
      carry_q  <= 1'b0;
      wf_q     <= 1'b0;
      imm_q    <= 16'd0;
      ra_q     <= 3'd0;
      rb_q     <= 3'd0;
      rd_q     <= 3'd0;
      opnd_q   <= 16'd0;
      cnt_q    <= 16'd0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      ra_sel_q <= 3'd0;
      rb_sel_q <= 3'd0;
      rd_sel_q <= 3'd0;
      we_q     <= 1'b0;
      sf_we_q  <= 1'b0;
      alu_f_q  <= 4'd0;
      cmask_q  <= 1'b0;
      t16_q    <= 16'd0;
      agu_q    <= 16'd0;
      bypass_q <= 1'b0;
      zidx_q   <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      wf_q     <= wf_d;
      imm_q    <= imm_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      ra_sel_q <= ra_sel_d;
      rb_sel_q <= rb_sel_d;
      rd_sel_q <= rd_sel_d;
      we_q     <= we_d;
      sf_we_q  <= sf_we_d;
      alu_f_q  <= alu_f_d;
      cmask_q  <= cmask_d;
      t16_q    <= t16_d;
      agu_q    <= agu_d;
      bypass_q <= bypass_d;
      zidx_q   <= zidx_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      err_q    <= err_d;
    end
  end

  assign dec_ready        = ready_q;
  assign busy             = busy_q;
  assign rf_ra_sel        = ra_sel_q;
  assign rf_rb_sel        = rb_sel_q;
  assign rf_rd_sel        = rd_sel_q;
  assign rf_we            = we_q;
  assign rf_sf_we         = sf_we_q;
  assign alu_f            = alu_f_q;
  assign carry_mask       = cmask_q;
  assign sched_t16        = t16_q;
  assign sched_agu_t16    = agu_q;
  assign sched_bypass_b   = bypass_q;
  assign sched_zero_index = zidx_q;
  assign lsu_rd_req       = rd_req_q;
  assign lsu_wr_req       = wr_req_q;
  assign sched_err        = err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: table of register/immediate issues plus
// hand-written load, store, timeout and mid-MEM reset sequences.
module tb_alu_sched;

  logic        clk;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_alu_f;
  logic [1:0]  dec_mode;
  logic        dec_carry;
  logic        dec_wf;
  logic [15:0] dec_imm;
  logic [2:0]  dec_ra, dec_rb, dec_rd;
  logic [2:0]  rf_ra_sel, rf_rb_sel, rf_rd_sel;
  logic        rf_we, rf_sf_we;
  logic [3:0]  alu_f;
  logic        carry_mask;
  logic [15:0] sched_t16, sched_agu_t16;
  logic        sched_bypass_b, sched_zero_index;
  logic        lsu_rd_req, lsu_wr_req;
  logic        lsu_ack;
  logic [15:0] lsu_rdata;
  logic        sched_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_sched #(.LSU_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_alu_f(dec_alu_f), .dec_mode(dec_mode), .dec_carry(dec_carry),
    .dec_wf(dec_wf), .dec_imm(dec_imm),
    .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_rd(dec_rd),
    .rf_ra_sel(rf_ra_sel), .rf_rb_sel(rf_rb_sel), .rf_rd_sel(rf_rd_sel),
    .rf_we(rf_we), .rf_sf_we(rf_sf_we),
    .alu_f(alu_f), .carry_mask(carry_mask),
    .sched_t16(sched_t16), .sched_agu_t16(sched_agu_t16),
    .sched_bypass_b(sched_bypass_b), .sched_zero_index(sched_zero_index),
    .lsu_rd_req(lsu_rd_req), .lsu_wr_req(lsu_wr_req),
    .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
    .sched_err(sched_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  f;
    logic        c;
    logic        wf;
    logic [15:0] imm;
    logic [2:0]  ra, rb, rd;
    logic        e_we;
    logic        e_sf;
    logic        e_byp;
    logic [15:0] e_t16;
    logic [2:0]  e_rb_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [3:0] f, input logic c,
                       input logic wf, input logic [15:0] imm,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd);
    dec_valid = 1'b1;
    dec_mode  = mode;
    dec_alu_f = f;
    dec_carry = c;
    dec_wf    = wf;
    dec_imm   = imm;
    dec_ra    = ra;
    dec_rb    = rb;
    dec_rd    = rd;
  endtask

  task automatic garble();
    dec_mode  = 2'b11;
    dec_alu_f = 4'h9;
    dec_carry = 1'b0;
    dec_wf    = 1'b0;
    dec_imm   = 16'h5A5A;
    dec_ra    = 3'd6;
    dec_rb    = 3'd6;
    dec_rd    = 3'd6;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " dec_ready"}, 32'(dec_ready), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, " rf_sf_we"}, 32'(rf_sf_we), 32'd0);
    chk({tag, " rd_req"}, 32'(lsu_rd_req), 32'd0);
    chk({tag, " wr_req"}, 32'(lsu_wr_req), 32'd0);
    chk({tag, " alu_f"}, 32'(alu_f), 32'd0);
    chk({tag, " agu_t16"}, 32'(sched_agu_t16), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mode   f     c     wf    imm       ra    rb    rd    we    sf    byp   t16       rb_sel
    vecs[0] = '{2'b01, 4'h0, 1'b0, 1'b1, 16'h1234, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b1, 16'h1234, 3'd0};
    vecs[1] = '{2'b00, 4'h5, 1'b1, 1'b0, 16'h00FF, 3'd1, 3'd6, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd6};
    vecs[2] = '{2'b00, 4'hF, 1'b0, 1'b1, 16'h0000, 3'd7, 3'd3, 3'd4, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd3};
    vecs[3] = '{2'b01, 4'hF, 1'b1, 1'b1, 16'hFFFF, 3'd2, 3'd5, 3'd7, 1'b0, 1'b1, 1'b1, 16'hFFFF, 3'd0};
    vecs[4] = '{2'b01, 4'hA, 1'b1, 1'b0, 16'h8001, 3'd3, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 16'h8001, 3'd0};
    vecs[5] = '{2'b00, 4'hE, 1'b0, 1'b1, 16'hABCD, 3'd5, 3'd7, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd7};

    rst_n = 1'b0;
    dec_valid = 1'b0;
    lsu_ack = 1'b0;
    lsu_rdata = 16'h0;
    garble();
    #12;
    chk_idle("reset");
    chk("reset sched_err", 32'(sched_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Register / immediate issues: accept at N, writeback at N+1, ready at N+2.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].mode, vecs[i].f, vecs[i].c, vecs[i].wf, vecs[i].imm,
            vecs[i].ra, vecs[i].rb, vecs[i].rd);
      tick();
      garble();
      @(negedge clk);
      chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d rf_sf_we", i), 32'(rf_sf_we), 32'(vecs[i].e_sf));
      chk($sformatf("v%0d bypass", i), 32'(sched_bypass_b), 32'(vecs[i].e_byp));
      chk($sformatf("v%0d t16", i), 32'(sched_t16), 32'(vecs[i].e_t16));
      chk($sformatf("v%0d rb_sel", i), 32'(rf_rb_sel), 32'(vecs[i].e_rb_sel));
      chk($sformatf("v%0d ra_sel", i), 32'(rf_ra_sel), 32'(vecs[i].ra));
      chk($sformatf("v%0d rd_sel", i), 32'(rf_rd_sel), 32'(vecs[i].rd));
      chk($sformatf("v%0d alu_f", i), 32'(alu_f), 32'(vecs[i].f));
      chk($sformatf("v%0d carry_mask", i), 32'(carry_mask), 32'(vecs[i].c));
      chk($sformatf("v%0d agu_t16", i), 32'(sched_agu_t16), 32'(vecs[i].imm));
      chk($sformatf("v%0d dec_ready", i), 32'(dec_ready), 32'd0);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d lsu req", i), 32'({lsu_rd_req, lsu_wr_req}), 32'd0);
      tick();
      dec_valid = 1'b0;
      @(negedge clk);
      chk_idle($sformatf("v%0d post", i));
    end

    // Load, rb=0, imm=0x40, ack in third MEM cycle.
    tick();
    issue(2'b10, 4'h2, 1'b1, 1'b1, 16'h0040, 3'd1, 3'd0, 3'd4);
    tick();
    dec_valid = 1'b0;
    garble();
    lsu_rdata = 16'h1111;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        lsu_ack = 1'b1;
        lsu_rdata = 16'hBEEF;
      end
      @(negedge clk);
      chk($sformatf("ld c%0d rd_req", c), 32'(lsu_rd_req), 32'd1);
      chk($sformatf("ld c%0d wr_req", c), 32'(lsu_wr_req), 32'd0);
      chk($sformatf("ld c%0d zero_index", c), 32'(sched_zero_index), 32'd1);
      chk($sformatf("ld c%0d agu_t16", c), 32'(sched_agu_t16), 32'h0040);
      chk($sformatf("ld c%0d ra_sel", c), 32'(rf_ra_sel), 32'd0);
      chk($sformatf("ld c%0d rf_we", c), 32'(rf_we), 32'd0);
      tick();
      lsu_ack = 1'b0;
      lsu_rdata = 16'h2222;
    end
    @(negedge clk);
    chk("ld exec rd_req", 32'(lsu_rd_req), 32'd0);
    chk("ld exec t16", 32'(sched_t16), 32'hBEEF);
    chk("ld exec bypass", 32'(sched_bypass_b), 32'd1);
    chk("ld exec rf_we", 32'(rf_we), 32'd1);
    chk("ld exec rf_sf_we", 32'(rf_sf_we), 32'd1);
    chk("ld exec rd_sel", 32'(rf_rd_sel), 32'd4);
    chk("ld exec ra_sel", 32'(rf_ra_sel), 32'd1);
    chk("ld exec zero_index", 32'(sched_zero_index), 32'd0);
    tick();
    @(negedge clk);
    chk_idle("ld post");

    // Store, rb=2, rd=5, ack in first MEM cycle.
    tick();
    issue(2'b11, 4'h3, 1'b0, 1'b1, 16'h0010, 3'd6, 3'd2, 3'd5);
    tick();
    dec_valid = 1'b0;
    lsu_ack = 1'b1;
    @(negedge clk);
    chk("st wr_req", 32'(lsu_wr_req), 32'd1);
    chk("st rd_req", 32'(lsu_rd_req), 32'd0);
    chk("st rb_sel", 32'(rf_rb_sel), 32'd5);
    chk("st ra_sel", 32'(rf_ra_sel), 32'd2);
    chk("st rf_we", 32'(rf_we), 32'd0);
    chk("st zero_index", 32'(sched_zero_index), 32'd0);
    tick();
    lsu_ack = 1'b0;
    @(negedge clk);
    chk_idle("st post");
    chk("st post sched_err", 32'(sched_err), 32'd0);

    // Load with no ack: four request cycles, then one sched_err pulse.
    tick();
    issue(2'b10, 4'h1, 1'b0, 1'b1, 16'h0002, 3'd2, 3'd1, 3'd3);
    tick();
    dec_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("to c%0d rd_req", c), 32'(lsu_rd_req), 32'd1);
      chk($sformatf("to c%0d sched_err", c), 32'(sched_err), 32'd0);
      chk($sformatf("to c%0d zero_index", c), 32'(sched_zero_index), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("to end sched_err", 32'(sched_err), 32'd1);
    chk_idle("to end");
    tick();
    @(negedge clk);
    chk("to after sched_err", 32'(sched_err), 32'd0);
    chk("to after rf_we", 32'(rf_we), 32'd0);

    // Same load with ack exactly on the limit cycle: ack wins.
    issue(2'b10, 4'h1, 1'b0, 1'b1, 16'h0002, 3'd2, 3'd1, 3'd3);
    tick();
    dec_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        lsu_ack = 1'b1;
        lsu_rdata = 16'hCAFE;
      end
      @(negedge clk);
      chk($sformatf("ak c%0d rd_req", c), 32'(lsu_rd_req), 32'd1);
      tick();
      lsu_ack = 1'b0;
    end
    @(negedge clk);
    chk("ak exec sched_err", 32'(sched_err), 32'd0);
    chk("ak exec rf_we", 32'(rf_we), 32'd1);
    chk("ak exec t16", 32'(sched_t16), 32'hCAFE);
    chk("ak exec rd_req", 32'(lsu_rd_req), 32'd0);
    tick();
    @(negedge clk);
    chk("ak post sched_err", 32'(sched_err), 32'd0);

    // Reset during MEM, spurious ack, then immediate accept after release.
    tick();
    issue(2'b10, 4'h7, 1'b1, 1'b1, 16'h0100, 3'd3, 3'd4, 3'd2);
    tick();
    dec_valid = 1'b0;
    tick();
    #2;
    chk("rst pre rd_req", 32'(lsu_rd_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst async");
    chk("rst async zero_index", 32'(sched_zero_index), 32'd0);
    chk("rst async ra_sel", 32'(rf_ra_sel), 32'd0);
    chk("rst async sched_err", 32'(sched_err), 32'd0);
    lsu_ack = 1'b1;
    lsu_rdata = 16'hDEAD;
    tick();
    rst_n = 1'b1;
    issue(2'b00, 4'h4, 1'b0, 1'b0, 16'h0033, 3'd1, 3'd2, 3'd6);
    tick();
    dec_valid = 1'b0;
    @(negedge clk);
    chk("rel exec rf_we", 32'(rf_we), 32'd1);
    chk("rel exec bypass", 32'(sched_bypass_b), 32'd0);
    chk("rel exec rb_sel", 32'(rf_rb_sel), 32'd2);
    chk("rel exec rd_sel", 32'(rf_rd_sel), 32'd6);
    chk("rel exec t16", 32'(sched_t16), 32'd0);
    chk("rel exec rd_req", 32'(lsu_rd_req), 32'd0);
    chk("rel exec sched_err", 32'(sched_err), 32'd0);
    tick();
    lsu_ack = 1'b0;
    @(negedge clk);
    chk_idle("rel post");
    chk("rel post sched_err", 32'(sched_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
